// File: rtl/mouse_cursor_tracker_if.sv
// Report-in / cursor-out bundle between the USB HID host and the cursor tracker.
// The slave modport is the tracker; the master modport is the HID host side.
interface mouse_cursor_tracker_if #(
   parameter int POS_W = 10
);
   logic             report;
   logic [7:0]       mouse_dx;
   logic [7:0]       mouse_dy;
   logic [2:0]       mouse_btn;
   logic [1:0]       scale;
   logic [POS_W-1:0] cur_x;
   logic [POS_W-1:0] cur_y;
   logic [2:0]       btn;
   logic [2:0]       click;
   logic             dbl_click;
   logic             moved;
   logic             snap_toggle;

   modport slave (
      input  report, mouse_dx, mouse_dy, mouse_btn, scale,
      output cur_x, cur_y, btn, click, dbl_click, moved, snap_toggle
   );

   modport master (
      output report, mouse_dx, mouse_dy, mouse_btn, scale,
      input  cur_x, cur_y, btn, click, dbl_click, moved, snap_toggle
   );
endinterface

// File: rtl/mouse_cursor_tracker.sv
// Relative HID mouse reports -> absolute clamped cursor, button edges, left
// double-click and a snapshot toggle for the pixel-clock side.

// One axis: capture a scaled delta, then add it to the position and clamp.
module mct_axis #(
   parameter int RES   = 640,
   parameter int POS_W = 10,
   parameter int SW    = 13
) (
   input  logic             clk12,
   input  logic             reset_n,
   input  logic             cap,
   input  logic             commit,
   input  logic [7:0]       raw,
   input  logic [1:0]       scale,
   output logic [POS_W-1:0] pos,
   output logic             changed
);
   localparam logic [POS_W-1:0]     POS_RST = POS_W'(RES / 2);
   localparam logic signed [SW-1:0] MAX_S   = SW'(RES - 1);
   localparam logic [POS_W-1:0]     MAX_P   = POS_W'(RES - 1);

   logic signed [SW-1:0] delta;
   logic signed [SW-1:0] sum;
   logic [POS_W-1:0]     pos_nxt;

   always_ff @(posedge clk12) begin
      if (!reset_n)
         delta <= '0;
      else if (cap)
         delta <= $signed({{(SW-8){raw[7]}}, raw}) <<< scale;
   end

   // Always sums against the live position so back-to-back deltas chain.
   always_comb begin
      sum     = $signed({{(SW-POS_W){1'b0}}, pos}) + delta;
      pos_nxt = sum[POS_W-1:0];
      if (sum < 0)
         pos_nxt = '0;
      else if (sum > MAX_S)
         pos_nxt = MAX_P;
   end

   always_ff @(posedge clk12) begin
      if (!reset_n) begin
         pos     <= POS_RST;
         changed <= 1'b0;
      end else begin
         changed <= commit && (pos_nxt != pos);
         if (commit)
            pos <= pos_nxt;
      end
   end
endmodule

module mouse_cursor_tracker #(
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int POS_W     = 10,
   parameter int DBL_TICKS = 3_000_000
) (
   input  logic                   clk12,
   input  logic                   reset_n,
   mouse_cursor_tracker_if.slave  bus
);
   localparam int SW     = ((POS_W > 11) ? POS_W : 11) + 2;
   localparam int NUM_AX = 2;
   localparam int TW     = $clog2(DBL_TICKS + 1);
   localparam logic [TW-1:0] TMAX = TW'(DBL_TICKS);

   typedef enum logic {IDLE, ARMED} dbl_state_t;

   // vld_pipe[0]: stage-1 holds a captured report; vld_pipe[1]: stage 2 committed.
   logic [1:0]                    vld_pipe;
   logic [NUM_AX-1:0][7:0]        raw;
   logic [NUM_AX-1:0][POS_W-1:0]  pos;
   logic [NUM_AX-1:0]             changed;
   logic [2:0]                    btn_q;
   logic [2:0]                    click_q;
   logic                          snap_q;
   logic                          press;
   dbl_state_t                    state, state_nxt;
   logic [TW-1:0]                 timer, timer_nxt;
   logic                          dbl_q, dbl_nxt;

   assign raw = {bus.mouse_dy, bus.mouse_dx};

   genvar g;
   generate
      for (g = 0; g < NUM_AX; g++) begin : g_ax
         localparam int RES = (g == 0) ? H_RES : V_RES;
         mct_axis #(.RES(RES), .POS_W(POS_W), .SW(SW)) u_axis (
            .clk12   (clk12),
            .reset_n (reset_n),
            .cap     (bus.report),
            .commit  (vld_pipe[0]),
            .raw     (raw[g]),
            .scale   (bus.scale),
            .pos     (pos[g]),
            .changed (changed[g])
         );
      end
   endgenerate

   always_ff @(posedge clk12) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         btn_q    <= '0;
         click_q  <= '0;
         snap_q   <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[0], bus.report};
         snap_q   <= snap_q ^ vld_pipe[1];
         click_q  <= '0;
         if (bus.report) begin
            btn_q   <= bus.mouse_btn;
            click_q <= bus.mouse_btn & ~btn_q;
         end
      end
   end

   // The FSM looks at the press being captured so dbl_click lands with click[0].
   assign press = bus.report & bus.mouse_btn[0] & ~btn_q[0];

   always_ff @(posedge clk12) begin
      if (!reset_n) begin
         state <= IDLE;
         timer <= '0;
         dbl_q <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         dbl_q <= dbl_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      dbl_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               state_nxt = ARMED;
               timer_nxt = '0;
            end
         end
         ARMED: begin
            if (press && timer < TMAX) begin
               dbl_nxt   = 1'b1;
               state_nxt = IDLE;
            end else if (press) begin
               timer_nxt = '0;   // window already closed: this is a fresh first click
            end else if (timer == TMAX) begin
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.cur_x       = pos[0];
   assign bus.cur_y       = pos[1];
   assign bus.btn         = btn_q;
   assign bus.click       = click_q;
   assign bus.dbl_click   = dbl_q;
   assign bus.moved       = |changed;
   assign bus.snap_toggle = snap_q;
endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed checks of cursor accumulation/clamping, button edges, double-click
// window and reset behaviour of mouse_cursor_tracker.
module tb_mouse_cursor_tracker;
   localparam int DT = 200;

   logic clk12   = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   rpt_cnt = 0;
   int   dbl_cnt = 0;
   int   base;

   mouse_cursor_tracker_if #(.POS_W(10)) bus();

   mouse_cursor_tracker #(
      .H_RES(640), .V_RES(480), .POS_W(10), .DBL_TICKS(DT)
   ) dut (
      .clk12   (clk12),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk12 = ~clk12;

   always @(posedge clk12) if (bus.dbl_click) dbl_cnt++;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk12);
         #1;
      end
   endtask

   // Drives a one-cycle report; returns 1ns after the capture edge (T+1).
   task automatic send(input int dx, input int dy, input logic [2:0] b, input logic [1:0] sc);
      bus.mouse_dx  = 8'(dx);
      bus.mouse_dy  = 8'(dy);
      bus.mouse_btn = b;
      bus.scale     = sc;
      bus.report    = 1'b1;
      rpt_cnt++;
      step();
      bus.report    = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      rpt_cnt = 0;
   endtask

   initial begin
      bus.report = 1'b0; bus.mouse_dx = '0; bus.mouse_dy = '0;
      bus.mouse_btn = '0; bus.scale = '0;
      step(3);
      chk("rst_x", bus.cur_x, 320);
      chk("rst_y", bus.cur_y, 240);
      chk("rst_btn", bus.btn, 0);
      chk("rst_click", bus.click, 0);
      chk("rst_dbl", bus.dbl_click, 0);
      chk("rst_moved", bus.moved, 0);
      chk("rst_snap", bus.snap_toggle, 0);
      reset_n = 1'b1;
      step();

      // Basic move, latency of cursor and snapshot toggle
      send(5, -3, 3'b000, 2'd0);
      chk("t1_moved", bus.moved, 0);
      step();
      chk("t2_x", bus.cur_x, 325);
      chk("t2_y", bus.cur_y, 237);
      chk("t2_moved", bus.moved, 1);
      chk("t2_snap", bus.snap_toggle, 0);
      step();
      chk("t3_snap", bus.snap_toggle, 1);
      chk("t3_moved", bus.moved, 0);

      // Three back-to-back reports walking to (635,2)
      send(127, -128, 3'b000, 2'd0);
      send(127, -107, 3'b000, 2'd0);
      send(56, 0, 3'b000, 2'd0);
      step();
      chk("walk_x", bus.cur_x, 635);
      chk("walk_y", bus.cur_y, 2);
      chk("walk_moved", bus.moved, 1);
      step(2);
      chk("walk_snap", bus.snap_toggle, rpt_cnt % 2);

      // Clamp at right and top edges
      send(10, -10, 3'b000, 2'd0);
      step();
      chk("clamp_hi_x", bus.cur_x, 639);
      chk("clamp_lo_y", bus.cur_y, 0);
      step(2);

      // Zero delta: no move, snapshot still toggles
      send(0, 0, 3'b000, 2'd0);
      step();
      chk("zero_moved", bus.moved, 0);
      chk("zero_x", bus.cur_x, 639);
      step();
      chk("zero_snap", bus.snap_toggle, rpt_cnt % 2);
      step();

      // Scaled deltas clamp to the opposite corners
      send(-128, 127, 3'b000, 2'd3);
      step();
      chk("scale_x", bus.cur_x, 0);
      chk("scale_y", bus.cur_y, 479);
      chk("scale_moved", bus.moved, 1);
      step(2);

      // Button edges
      send(0, 0, 3'b001, 2'd0);
      chk("btnA_click", bus.click, 1);
      chk("btnA_btn", bus.btn, 1);
      send(0, 0, 3'b011, 2'd0);
      chk("btnB_click", bus.click, 2);
      chk("btnB_btn", bus.btn, 3);
      step();
      chk("btnB_pulse", bus.click, 0);
      send(0, 0, 3'b000, 2'd0);
      chk("btnR_click", bus.click, 0);
      chk("btnR_btn", bus.btn, 0);
      step(DT + 20);

      // Double click inside the window
      base = dbl_cnt;
      send(0, 0, 3'b001, 2'd0);
      chk("dc1_click", bus.click, 1);
      chk("dc1_dbl", bus.dbl_click, 0);
      send(0, 0, 3'b000, 2'd0);
      step(65);
      send(0, 0, 3'b001, 2'd0);
      chk("dc2_click", bus.click, 1);
      chk("dc2_dbl", bus.dbl_click, 1);
      step();
      chk("dc2_pulse", bus.dbl_click, 0);
      send(0, 0, 3'b000, 2'd0);
      step(DT + 20);
      chk("dc_count", dbl_cnt - base, 1);

      // Second press after the window has closed
      base = dbl_cnt;
      send(0, 0, 3'b001, 2'd0);
      send(0, 0, 3'b000, 2'd0);
      step(208);
      send(0, 0, 3'b001, 2'd0);
      chk("slow_dbl", bus.dbl_click, 0);
      send(0, 0, 3'b000, 2'd0);
      step(DT + 20);
      chk("slow_count", dbl_cnt - base, 0);

      // Triple click yields exactly one double-click
      base = dbl_cnt;
      send(0, 0, 3'b001, 2'd0);
      send(0, 0, 3'b000, 2'd0);
      step(10);
      send(0, 0, 3'b001, 2'd0);
      chk("tri2_dbl", bus.dbl_click, 1);
      send(0, 0, 3'b000, 2'd0);
      step(10);
      send(0, 0, 3'b001, 2'd0);
      chk("tri3_dbl", bus.dbl_click, 0);
      send(0, 0, 3'b000, 2'd0);
      step(5);
      chk("tri_count", dbl_cnt - base, 1);

      // Consecutive reports chain; reset kills an in-flight report
      do_reset();
      step();
      send(1, 0, 3'b000, 2'd0);
      send(1, 0, 3'b000, 2'd0);
      chk("b2b_x1", bus.cur_x, 321);
      step();
      chk("b2b_x2", bus.cur_x, 322);
      step(2);
      send(1, 0, 3'b001, 2'd0);
      reset_n = 1'b0;
      step();
      chk("midrst_x", bus.cur_x, 320);
      chk("midrst_y", bus.cur_y, 240);
      chk("midrst_moved", bus.moved, 0);
      chk("midrst_btn", bus.btn, 0);
      chk("midrst_snap", bus.snap_toggle, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_moved", bus.moved, 0);
         chk("post_snap", bus.snap_toggle, 0);
      end
      chk("post_x", bus.cur_x, 320);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mouse_cursor_tracker.md
# mouse_cursor_tracker

Converts relative HID mouse reports from `usb_hid_host` into an absolute, screen-clamped cursor position and button state in the clk12 domain. It also provides per-button click pulses, left double-click detection, and a toggle flag so the pixel-clock display logic can resynchronise a stable snapshot. It replaces the free-running modulo accumulator between the USB host and the VGA/DVI overlay.

## Interface
Parameters:
- `H_RES`, default 640: horizontal extent; cursor x is in 0..H_RES-1.
- `V_RES`, default 480: vertical extent; cursor y is in 0..V_RES-1.
- `POS_W`, default 10: width of the position outputs; must satisfy 2^POS_W ≥ max(H_RES, V_RES).
- `DBL_TICKS`, default 3_000_000: double-click window in clk12 cycles (250 ms).

Ports:
- `clk12`  in  1  12 MHz USB clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `report`  in  1  one-cycle pulse: new mouse report valid this cycle.
- `mouse_dx`  in  8  signed delta X, positive = right; sampled only when `report`=1.
- `mouse_dy`  in  8  signed delta Y, positive = down; sampled only when `report`=1.
- `mouse_btn`  in  3  buttons [0]=left, [1]=right, [2]=middle; sampled only when `report`=1.
- `scale`  in  2  sensitivity; delta is shifted left by `scale` (×1, ×2, ×4, ×8).
- `cur_x`  out  POS_W  cursor X.
- `cur_y`  out  POS_W  cursor Y.
- `btn`  out  3  registered button state.
- `click`  out  3  one-cycle pulse per button on press (0→1).
- `dbl_click`  out  1  one-cycle pulse on a left double-click.
- `moved`  out  1  one-cycle pulse when the position changed.
- `snap_toggle`  out  1  toggles once per committed report; for CDC.

## Operation
- Reset values:
  - `cur_x` = H_RES/2 (320); `cur_y` = V_RES/2 (240).
  - `btn`, `click`, `dbl_click`, `moved`, `snap_toggle` = 0.
  - Pipeline valid flags are cleared and the double-click timer is disarmed.
- Stage 1 (capture), on `report`:
  - Sign-extend dx and dy to 13 bits, then shift left by `scale`. Range is -1024..+1016.
  - Register the deltas and `mouse_btn`.
  - Compute `click[i]` = new_btn[i] & ~btn[i]; update `btn`.
- Stage 2 (accumulate/clamp):
  - sum = zero-extended cur + delta, 13-bit signed.
  - If sum < 0, the result is 0. If sum > RES-1, the result is RES-1. Otherwise the result is sum.
  - Write `cur_x`/`cur_y`. Pulse `moved` if either coordinate differs from its previous value.
  - Stage 2 always uses the current `cur_*`, so back-to-back `report` pulses on consecutive cycles are both applied with no hazard or loss.
- Snapshot:
  - `snap_toggle` inverts one cycle after the stage-2 commit.
  - Downstream logic synchronises `snap_toggle` through two flops, then samples `cur_x`/`cur_y`/`btn`.
  - These outputs are guaranteed stable from the toggle until the next `report` + 2 cycles.
- Double-click FSM, states IDLE and ARMED:
  - IDLE: on `click[0]`, go to ARMED and load the timer to 0.
  - ARMED: the timer increments every cycle.
    - `click[0]` with timer < DBL_TICKS pulses `dbl_click` in the same cycle as `click[0]` and returns to IDLE (a third click re-arms; it does not fire a second double-click).
    - Timer reaching DBL_TICKS returns to IDLE.
- Reset mid-operation: a report in flight is discarded; no pulse appears after reset deasserts.
- A change of `scale` takes effect on the next captured report.

## Timing
- `report` at cycle T:
  - `btn` and `click` are valid at T+1.
  - `cur_x`, `cur_y` and `moved` are valid at T+2.
  - `snap_toggle` inverts at T+3.
- `dbl_click` is coincident with the second `click[0]` pulse (T+1).
- All pulse outputs last exactly one cycle.
- Throughput is one report per cycle.

## Test plan
- Reset, then `report` with dx=+5, dy=-3, scale=0 → at T+2 cur=(325,237), `moved`=1; `snap_toggle`=1 at T+3.
- cur=(635,2), report dx=+10, dy=-10 → cur=(639,0). Then report dx=-128, dy=+127, scale=3 → cur=(0,480-1 clamp → 479).
- Report dx=0, dy=0 while at (639,0) → `moved` stays 0; `snap_toggle` still toggles.
- btn 000→001 on report A, then 001→011 on report B → `click`=001 at A+1, then `click`=010 at B+1; `btn`=011.
- Left press at t0, release, press again at t0+1_000_000 → `dbl_click` pulse. Repeat with spacing DBL_TICKS+10 → no pulse. Triple click within the window → exactly one pulse.
- Reports on two consecutive cycles with dx=+1 each, from x=320 → x=321 at T+2, then 322 at T+3. Assert `reset_n`=0 at T+1 of a third report → outputs return to reset values and no `moved` pulse appears.
